// File: rtl/pmu_i2c_target.sv
// I2C target modelling the PMU register file: START/STOP decode, 7-bit address match,
// subaddress pointer, byte writes/reads. Optional PMU_I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample filter.
module pmu_i2c_target #(
  parameter logic [6:0] DEV_ADDR      = 7'h34,
  parameter int         REG_ADDR_BITS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     sda_oe,
  input  logic                     force_nak,
  input  logic                     host_we,
  input  logic [REG_ADDR_BITS-1:0] host_addr,
  input  logic [7:0]               host_wdata,
  output logic                     reg_wr,
  output logic [7:0]               reg_addr,
  output logic [7:0]               reg_wdata,
  output logic                     busy
);

  localparam int DEPTH = 1 << REG_ADDR_BITS;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_e;

  logic sclS1_q, sclS2_q, sdaS1_q, sdaS2_q;
  logic sScl, sSda;
  logic sclPrev_q, sdaPrev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclS1_q <= 1'b1;
      sclS2_q <= 1'b1;
      sdaS1_q <= 1'b1;
      sdaS2_q <= 1'b1;
    end else begin
      sclS1_q <= scl_in;
      sclS2_q <= sclS1_q;
      sdaS1_q <= sda_in;
      sdaS2_q <= sdaS1_q;
    end
  end

`ifdef PMU_I2C_TARGET_GLITCH_FILTER_EN
  // A line's filtered value follows the synchronizer only once three consecutive samples agree.
  logic [1:0] sclHist_q, sdaHist_q;
  logic       sclHold_q, sdaHold_q;
  logic       sclStable, sdaStable;

  assign sclStable = (sclS2_q == sclHist_q[0]) && (sclS2_q == sclHist_q[1]);
  assign sdaStable = (sdaS2_q == sdaHist_q[0]) && (sdaS2_q == sdaHist_q[1]);
  assign sScl      = sclStable ? sclS2_q : sclHold_q;
  assign sSda      = sdaStable ? sdaS2_q : sdaHold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclHist_q <= 2'b11;
      sdaHist_q <= 2'b11;
      sclHold_q <= 1'b1;
      sdaHold_q <= 1'b1;
    end else begin
      sclHist_q <= {sclHist_q[0], sclS2_q};
      sdaHist_q <= {sdaHist_q[0], sdaS2_q};
      sclHold_q <= sScl;
      sdaHold_q <= sSda;
    end
  end
`else
  assign sScl = sclS2_q;
  assign sSda = sdaS2_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclPrev_q <= sScl;
      sdaPrev_q <= sSda;
    end
  end

  logic sclRise, sclFall, startDet, stopDet;
  assign sclRise  = sScl & ~sclPrev_q;
  assign sclFall  = ~sScl & sclPrev_q;
  assign startDet = sScl & sclPrev_q & sdaPrev_q & ~sSda;
  assign stopDet  = sScl & sclPrev_q & ~sdaPrev_q & sSda;

  state_e     state_q;
  logic [2:0] bitCnt_q;
  logic [7:0] shift_q;
  logic [7:0] ptr_q;
  logic       ackPhase_q;
  logic       loadPend_q;
  logic       rw_q;
  logic       sdaOe_q;
  logic       busy_q;
  logic       regWr_q;
  logic [7:0] regAddr_q;
  logic [7:0] regWdata_q;
  logic [7:0] regs_q [DEPTH];

  logic [7:0] rxByte;
  logic       ptrInRange;
  logic [7:0] rdByte;
  logic       byteDone;
  logic       i2cWe;

  assign rxByte     = {shift_q[6:0], sSda};
  assign ptrInRange = ({1'b0, ptr_q} < 9'(DEPTH));
  assign rdByte     = ptrInRange ? regs_q[ptr_q[REG_ADDR_BITS-1:0]] : 8'hFF;
  assign byteDone   = sclRise && (bitCnt_q == 3'd7);
  assign i2cWe      = (state_q == WDATA) && byteDone && ptrInRange && !startDet && !stopDet;

  // Host preload and I2C write share the array; the I2C write is last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
    end else begin
      if (host_we) regs_q[host_addr] <= host_wdata;
      if (i2cWe)   regs_q[ptr_q[REG_ADDR_BITS-1:0]] <= rxByte;
    end
  end

  // ACK states drive SDA low between the two falling edges that bracket the ninth clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bitCnt_q   <= 3'd0;
      shift_q    <= 8'h00;
      ptr_q      <= 8'h00;
      ackPhase_q <= 1'b0;
      loadPend_q <= 1'b0;
      rw_q       <= 1'b0;
      sdaOe_q    <= 1'b0;
      busy_q     <= 1'b0;
      regWr_q    <= 1'b0;
      regAddr_q  <= 8'h00;
      regWdata_q <= 8'h00;
    end else begin
      regWr_q <= 1'b0;
      if (startDet || stopDet) begin
        state_q    <= startDet ? ADDR : IDLE;
        bitCnt_q   <= 3'd0;
        sdaOe_q    <= 1'b0;
        busy_q     <= 1'b0;
        ackPhase_q <= 1'b0;
        loadPend_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR, SUB, WDATA: begin
            if (sclRise) begin
              shift_q  <= rxByte;
              bitCnt_q <= bitCnt_q + 3'd1;
            end
            if (byteDone) begin
              ackPhase_q <= 1'b0;
              if (state_q == ADDR) begin
                if (rxByte[7:1] == DEV_ADDR && !force_nak) begin
                  state_q <= ADDR_ACK;
                  busy_q  <= 1'b1;
                  rw_q    <= rxByte[0];
                end else begin
                  state_q <= IGNORE;
                end
              end else if (state_q == SUB) begin
                ptr_q   <= rxByte;
                state_q <= SUB_ACK;
              end else begin
                regWr_q    <= 1'b1;
                regAddr_q  <= ptr_q;
                regWdata_q <= rxByte;
                ptr_q      <= ptr_q + 8'd1;
                state_q    <= WDATA_ACK;
              end
            end
          end
          ADDR_ACK, SUB_ACK, WDATA_ACK: begin
            if (sclFall) begin
              if (!ackPhase_q) begin
                sdaOe_q    <= 1'b1;
                ackPhase_q <= 1'b1;
              end else begin
                sdaOe_q    <= 1'b0;
                ackPhase_q <= 1'b0;
                if (state_q == ADDR_ACK && rw_q) begin
                  state_q <= RDATA;
                  shift_q <= rdByte;
                  sdaOe_q <= ~rdByte[7];
                end else if (state_q == ADDR_ACK) begin
                  state_q <= SUB;
                end else begin
                  state_q <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (sclFall) begin
              if (loadPend_q) begin
                shift_q    <= rdByte;
                sdaOe_q    <= ~rdByte[7];
                loadPend_q <= 1'b0;
              end else begin
                shift_q <= {shift_q[6:0], 1'b1};
                sdaOe_q <= ~shift_q[6];
              end
            end
            if (sclRise) begin
              bitCnt_q <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                state_q    <= RDATA_ACK;
                ackPhase_q <= 1'b0;
              end
            end
          end
          RDATA_ACK: begin
            if (sclFall && !ackPhase_q) begin
              sdaOe_q    <= 1'b0;
              ackPhase_q <= 1'b1;
            end else if (sclRise && ackPhase_q) begin
              ackPhase_q <= 1'b0;
              if (!sSda) begin
                ptr_q      <= ptr_q + 8'd1;
                loadPend_q <= 1'b1;
                state_q    <= RDATA;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  assign sda_oe    = sdaOe_q;
  assign busy      = busy_q;
  assign reg_wr    = regWr_q;
  assign reg_addr  = regAddr_q;
  assign reg_wdata = regWdata_q;

endmodule

// File: tb/tb_pmu_i2c_target.sv
// Directed bench for pmu_i2c_target: a bit-banged I2C master on an open-drain SDA line.
`timescale 1ns/1ps
module tb_pmu_i2c_target;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       masterScl, masterSda;
  logic       force_nak, host_we;
  logic [5:0] host_addr;
  logic [7:0] host_wdata;
  logic       sda_oe, reg_wr, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic       sdaLine;

  int         total = 0;
  int         bad = 0;
  int         wrCount = 0;
  logic [7:0] lastAddr = 8'h00;
  logic [7:0] lastData = 8'h00;
  logic       busySeen = 1'b0;

  assign sdaLine = masterSda & ~sda_oe;

  pmu_i2c_target dut (
    .clk(clk), .reset(reset), .scl_in(masterScl), .sda_in(sdaLine), .sda_oe(sda_oe),
    .force_nak(force_nak), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record write strobes and any busy assertion, sampled away from the active edge.
  always @(negedge clk) begin
    if (reg_wr) begin
      wrCount  = wrCount + 1;
      lastAddr = reg_addr;
      lastData = reg_wdata;
    end
    if (busy) busySeen = 1'b1;
  end

  task automatic i2cStart;
    masterSda = 1'b1; #Q;
    masterScl = 1'b1; #Q;
    masterSda = 1'b0; #Q;
    masterScl = 1'b0; #Q;
  endtask

  task automatic i2cStop;
    masterSda = 1'b0; #Q;
    masterScl = 1'b1; #Q;
    masterSda = 1'b1; #Q;
  endtask

  task automatic sendBit(input logic b);
    masterSda = b; #Q;
    masterScl = 1'b1; #(2*Q);
    masterScl = 1'b0; #Q;
  endtask

  task automatic writeByte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
    masterSda = 1'b1; #Q;
    masterScl = 1'b1; #Q;
    ack = ~sdaLine; #Q;
    masterScl = 1'b0; #Q;
  endtask

  task automatic readByte(input logic ackIt, output logic [7:0] d);
    d = 8'h00;
    masterSda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #Q; masterScl = 1'b1;
      #Q; d = {d[6:0], sdaLine};
      #Q; masterScl = 1'b0;
      #Q;
    end
    masterSda = ~ackIt; #Q;
    masterScl = 1'b1; #(2*Q);
    masterScl = 1'b0; #Q;
    masterSda = 1'b1;
  endtask

  task automatic hostWrite(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; masterScl = 1'b1; masterSda = 1'b1;
    force_nak = 1'b0; host_we = 1'b0; host_addr = 6'd0; host_wdata = 8'h00;
    repeat (4) @(negedge clk);
    total++; if (sda_oe !== 1'b0)     begin bad++; $display("[TB] FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    total++; if (reg_wr !== 1'b0)     begin bad++; $display("[TB] FAIL reset_reg_wr got=%b exp=0", reg_wr); end
    total++; if (reg_addr !== 8'h00)  begin bad++; $display("[TB] FAIL reset_reg_addr got=%h exp=00", reg_addr); end
    total++; if (reg_wdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_reg_wdata got=%h exp=00", reg_wdata); end
    total++; if (busy !== 1'b0)       begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_single;
    logic a0, a1, a2;
    int   w0;
    w0 = wrCount;
    i2cStart;
    writeByte(8'h68, a0);
    writeByte(8'h10, a1);
    writeByte(8'h9B, a2);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL wr1_busy_mid got=%b exp=1", busy); end
    i2cStop;
    total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("[TB] FAIL wr1_acks got=%b exp=111", {a0, a1, a2}); end
    total++; if (wrCount - w0 !== 1) begin bad++; $display("[TB] FAIL wr1_pulses got=%0d exp=1", wrCount - w0); end
    total++; if (lastAddr !== 8'h10) begin bad++; $display("[TB] FAIL wr1_addr got=%h exp=10", lastAddr); end
    total++; if (lastData !== 8'h9B) begin bad++; $display("[TB] FAIL wr1_data got=%h exp=9b", lastData); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL wr1_busy_stop got=%b exp=0", busy); end
  endtask

  task automatic test_host_preload_read;
    logic       a0, a1, a2;
    logic [7:0] d;
    hostWrite(6'h32, 8'h1D);
    i2cStart;
    writeByte(8'h68, a0);
    writeByte(8'h32, a1);
    i2cStop;
    i2cStart;
    writeByte(8'h69, a2);
    readByte(1'b0, d);
    i2cStop;
    total++; if (a2 !== 1'b1) begin bad++; $display("[TB] FAIL pre_rd_addr_ack got=%b exp=1", a2); end
    total++; if (d !== 8'h1D) begin bad++; $display("[TB] FAIL pre_rd_data got=%h exp=1d", d); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL pre_rd_busy got=%b exp=0", busy); end
    total++; if (sda_oe !== 1'b0) begin bad++; $display("[TB] FAIL pre_rd_sda_oe got=%b exp=0", sda_oe); end
    i2cStart;
    writeByte(8'h68, a0);
    writeByte(8'h10, a1);
    i2cStart;
    writeByte(8'h69, a2);
    readByte(1'b0, d);
    i2cStop;
    total++; if (d !== 8'h9B) begin bad++; $display("[TB] FAIL readback_10 got=%h exp=9b", d); end
  endtask

  task automatic test_multi_write;
    logic       a0, a1, a2, a3;
    logic [7:0] d0, d1;
    int         w0;
    w0 = wrCount;
    i2cStart;
    writeByte(8'h68, a0);
    writeByte(8'h20, a1);
    writeByte(8'h55, a2);
    writeByte(8'hAA, a3);
    i2cStop;
    total++; if (wrCount - w0 !== 2) begin bad++; $display("[TB] FAIL mw_pulses got=%0d exp=2", wrCount - w0); end
    total++; if (lastAddr !== 8'h21) begin bad++; $display("[TB] FAIL mw_last_addr got=%h exp=21", lastAddr); end
    total++; if (lastData !== 8'hAA) begin bad++; $display("[TB] FAIL mw_last_data got=%h exp=aa", lastData); end
    hostWrite(6'h22, 8'h77);
    i2cStart;
    writeByte(8'h69, a0);
    readByte(1'b0, d0);
    i2cStop;
    total++; if (d0 !== 8'h77) begin bad++; $display("[TB] FAIL mw_ptr_22 got=%h exp=77", d0); end
    i2cStart;
    writeByte(8'h68, a0);
    writeByte(8'h20, a1);
    i2cStart;
    writeByte(8'h69, a2);
    readByte(1'b1, d0);
    readByte(1'b0, d1);
    i2cStop;
    total++; if (d0 !== 8'h55) begin bad++; $display("[TB] FAIL mw_rd_20 got=%h exp=55", d0); end
    total++; if (d1 !== 8'hAA) begin bad++; $display("[TB] FAIL mw_rd_21 got=%h exp=aa", d1); end
  endtask

  task automatic test_nak;
    logic a0, a1, a2;
    int   w0;
    w0 = wrCount;
    busySeen = 1'b0;
    i2cStart;
    writeByte(8'h6A, a0);
    writeByte(8'h11, a1);
    i2cStop;
    total++; if ({a0, a1} !== 2'b00) begin bad++; $display("[TB] FAIL nak_wrong_addr_ack got=%b exp=00", {a0, a1}); end
    total++; if (wrCount !== w0) begin bad++; $display("[TB] FAIL nak_wrong_addr_wr got=%0d exp=%0d", wrCount, w0); end
    total++; if (busySeen !== 1'b0) begin bad++; $display("[TB] FAIL nak_wrong_addr_busy got=%b exp=0", busySeen); end
    force_nak = 1'b1;
    i2cStart;
    writeByte(8'h68, a0);
    writeByte(8'h12, a1);
    writeByte(8'h34, a2);
    i2cStop;
    force_nak = 1'b0;
    total++; if (a0 !== 1'b0) begin bad++; $display("[TB] FAIL nak_forced_ack got=%b exp=0", a0); end
    total++; if (wrCount !== w0) begin bad++; $display("[TB] FAIL nak_forced_wr got=%0d exp=%0d", wrCount, w0); end
    total++; if (busySeen !== 1'b0) begin bad++; $display("[TB] FAIL nak_forced_busy got=%b exp=0", busySeen); end
  endtask

  task automatic test_partial_stop;
    logic       a0, a1;
    logic [7:0] d;
    int         w0;
    hostWrite(6'h40 & 6'h3F, 8'hC3);
    w0 = wrCount;
    i2cStart;
    writeByte(8'h68, a0);
    writeByte(8'h00, a1);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b0);
    i2cStop;
    total++; if (wrCount !== w0) begin bad++; $display("[TB] FAIL partial_wr got=%0d exp=%0d", wrCount, w0); end
    total++; if (sda_oe !== 1'b0) begin bad++; $display("[TB] FAIL partial_sda_oe got=%b exp=0", sda_oe); end
    i2cStart;
    writeByte(8'h69, a0);
    readByte(1'b0, d);
    i2cStop;
    total++; if (d !== 8'hC3) begin bad++; $display("[TB] FAIL partial_ptr got=%h exp=c3", d); end
  endtask

  task automatic test_reset_mid_read;
    logic       a0, a1;
    logic [7:0] d;
    int         n;
    hostWrite(6'h05, 8'h3C);
    i2cStart;
    writeByte(8'h68, a0);
    writeByte(8'h05, a1);
    i2cStop;
    i2cStart;
    writeByte(8'h69, a0);
    n = 0;
    while (!sda_oe && n < 50) begin @(negedge clk); n++; end
    total++; if (sda_oe !== 1'b1) begin bad++; $display("[TB] FAIL rmr_drive0 got=%b exp=1", sda_oe); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (sda_oe !== 1'b0)     begin bad++; $display("[TB] FAIL rmr_sda_oe got=%b exp=0", sda_oe); end
    total++; if (busy !== 1'b0)       begin bad++; $display("[TB] FAIL rmr_busy got=%b exp=0", busy); end
    total++; if (reg_addr !== 8'h00)  begin bad++; $display("[TB] FAIL rmr_reg_addr got=%h exp=00", reg_addr); end
    total++; if (reg_wdata !== 8'h00) begin bad++; $display("[TB] FAIL rmr_reg_wdata got=%h exp=00", reg_wdata); end
    total++; if (reg_wr !== 1'b0)     begin bad++; $display("[TB] FAIL rmr_reg_wr got=%b exp=0", reg_wr); end
    masterSda = 1'b1;
    masterScl = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    i2cStart;
    writeByte(8'h68, a0);
    writeByte(8'h10, a1);
    i2cStart;
    writeByte(8'h69, a0);
    readByte(1'b0, d);
    i2cStop;
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL rmr_regfile_cleared got=%h exp=00", d); end
  endtask

`ifdef PMU_I2C_TARGET_GLITCH_FILTER_EN
  task automatic test_glitch_filter;
    logic a0;
    busySeen = 1'b0;
    masterScl = 1'b1; masterSda = 1'b1;
    repeat (8) @(negedge clk);
    masterSda = 1'b0;
    repeat (2) @(negedge clk);
    masterSda = 1'b1;
    repeat (8) @(negedge clk);
    masterScl = 1'b0; #Q;
    writeByte(8'h68, a0);
    total++; if (a0 !== 1'b0) begin bad++; $display("[TB] FAIL glitch_start_ack got=%b exp=0", a0); end
    total++; if (busySeen !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy got=%b exp=0", busySeen); end
    i2cStop;
  endtask
`endif

  initial begin
    $display("[TB] starting pmu_i2c_target bench");
    test_reset;
    test_write_single;
    test_host_preload_read;
    test_multi_write;
    test_nak;
    test_partial_stop;
    test_reset_mid_read;
`ifdef PMU_I2C_TARGET_GLITCH_FILTER_EN
    test_glitch_filter;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
